// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core widths and register-file typedefs
package core_pkg;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;
endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy bits: set at issue, cleared by writeback
import core_pkg::*;

module reg_scoreboard #(
  parameter int NREGS    = core_pkg::NREGS,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  output logic [NREGS-1:0] clr_vec,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] set_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int r = 0; r < NREGS; r++) begin
      set_vec[r] = iss_valid && (iss_rd == AW'(r));
      clr_vec[r] = (we0 && (wa0 == AW'(r))) || (we1 && (wa1 == AW'(r)));
    end
    // Register 0 can never have an outstanding producer.
    if (ZERO_REG != 0) set_vec[0] = 1'b0;
  end

  // A same-cycle issue outranks the clear: it names a newer producer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_vec <= '0;
    else     busy_vec <= (busy_vec & ~clr_vec) | set_vec;
  end

endmodule

// File: rtl/reg_file_scb.sv
// rtl/reg_file_scb.sv - 2-read/2-write register file with bypass and busy scoreboard
import core_pkg::*;

module reg_file_scb #(
  parameter int XLEN     = core_pkg::XLEN,
  parameter int NREGS    = core_pkg::NREGS,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [XLEN-1:0]  rd1,
  output logic [XLEN-1:0]  rd2,
  output logic             rd1_busy,
  output logic             rd2_busy,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [XLEN-1:0]  wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [XLEN-1:0]  wd1,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic [NREGS-1:0] busy_vec
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] clr_vec;
  logic             wen0, wen1;

  assign wen0 = we0 && !((ZERO_REG != 0) && (wa0 == '0));
  assign wen1 = we1 && !((ZERO_REG != 0) && (wa1 == '0));

  // Port 1 is written last so the load result wins an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (wen0) regs[wa0] <= wd0;
      if (wen1) regs[wa1] <= wd1;
    end
  end

  function automatic logic [XLEN-1:0] read_sel(input logic [AW-1:0] ra);
    logic [XLEN-1:0] v;
    v = regs[ra];
    if (BYPASS != 0) begin
      if (we0 && (wa0 == ra)) v = wd0;
      if (we1 && (wa1 == ra)) v = wd1;
    end
    if ((ZERO_REG != 0) && (ra == '0)) v = '0;
    return v;
  endfunction

  assign rd1 = read_sel(ra1);
  assign rd2 = read_sel(ra2);

  reg_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .we0       (we0),
    .wa0       (wa0),
    .we1       (we1),
    .wa1       (wa1),
    .clr_vec   (clr_vec),
    .busy_vec  (busy_vec)
  );

  // With bypass, a completing write releases the waiting reader in the same cycle.
  assign rd1_busy = busy_vec[ra1] && !((BYPASS != 0) && clr_vec[ra1]);
  assign rd2_busy = busy_vec[ra2] && !((BYPASS != 0) && clr_vec[ra2]);

endmodule
